uranus_cpu: RTL and testbench



---
 rtl/uranus_cpu.sv | 231 +++++++++++++++++++++++
 tb/tb_uranus_cpu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uranus_cpu.sv
// Multi-cycle MIPS32 integer core: IF, ID, EX, (MEM), WB; synchronous ROM/RAM with one-cycle read latency.
// Retire trace on debug_* only when URANUS_DEBUG_EN is defined, otherwise those ports are tied to 0.
module uranus_cpu #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_all,
  input  logic [4:0]  interrupt,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_read_data,
  output logic [31:0] debug_pc_addr,
  output logic [3:0]  debug_reg_write_en,
  output logic [4:0]  debug_reg_write_addr,
  output logic [31:0] debug_reg_write_data
);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
  state_t state, state_nx;

  logic [31:0] pc, npc, ir, a, b, res, tgt, mem_addr_q, wdata_q;
  logic [31:0] gpr [0:31];
  logic [4:0]  dst, irq_q;
  logic        wen, rom_en_q, ram_en_q;
  logic [3:0]  ram_we_q;

  logic [5:0]  op, fn;
  logic [4:0]  sh;
  logic [15:0] imm;
  logic [31:0] simm, zimm, pc4, mem_addr;
  logic        is_load, is_store;

  assign op       = ir[31:26];
  assign fn       = ir[5:0];
  assign sh       = ir[10:6];
  assign imm      = ir[15:0];
  assign simm     = {{16{imm[15]}}, imm};
  assign zimm     = {16'h0, imm};
  assign pc4      = pc + 32'd4;
  assign mem_addr = a + simm;
  assign is_load  = (op == 6'h23) || (op == 6'h20) || (op == 6'h24);
  assign is_store = (op == 6'h2b) || (op == 6'h28);

  logic unused_irq;
  assign unused_irq = ^irq_q;

  // Outputs are registered; stall_all only masks the strobes for the frozen cycle.
  assign rom_en         = rom_en_q & ~stall_all;
  assign rom_addr       = pc;
  assign ram_en         = ram_en_q & ~stall_all;
  assign ram_write_en   = ram_we_q & {4{~stall_all}};
  assign ram_addr       = mem_addr_q;
  assign ram_write_data = wdata_q;

  logic [31:0] ex_res, ex_target;
  logic [4:0]  ex_dst;
  logic        ex_wen, ex_taken;

  always_comb begin
    ex_res    = 32'h0;
    ex_dst    = ir[20:16];
    ex_wen    = 1'b0;
    ex_taken  = 1'b0;
    ex_target = pc4 + {simm[29:0], 2'b00};
    case (op)
      6'h00: begin
        ex_dst = ir[15:11];
        ex_wen = 1'b1;
        case (fn)
          6'h21: ex_res = a + b;
          6'h23: ex_res = a - b;
          6'h24: ex_res = a & b;
          6'h25: ex_res = a | b;
          6'h26: ex_res = a ^ b;
          6'h27: ex_res = ~(a | b);
          6'h2a: ex_res = {31'h0, $signed(a) < $signed(b)};
          6'h2b: ex_res = {31'h0, a < b};
          6'h00: ex_res = b << sh;
          6'h02: ex_res = b >> sh;
          6'h03: ex_res = $signed(b) >>> sh;
          6'h08: begin
            ex_wen    = 1'b0;
            ex_taken  = 1'b1;
            ex_target = a;
          end
          default: ex_wen = 1'b0;
        endcase
      end
      6'h09: begin ex_wen = 1'b1; ex_res = a + simm; end
      6'h0a: begin ex_wen = 1'b1; ex_res = {31'h0, $signed(a) < $signed(simm)}; end
      6'h0b: begin ex_wen = 1'b1; ex_res = {31'h0, a < simm}; end
      6'h0c: begin ex_wen = 1'b1; ex_res = a & zimm; end
      6'h0d: begin ex_wen = 1'b1; ex_res = a | zimm; end
      6'h0e: begin ex_wen = 1'b1; ex_res = a ^ zimm; end
      6'h0f: begin ex_wen = 1'b1; ex_res = {imm, 16'h0}; end
      6'h23, 6'h20, 6'h24: ex_wen = 1'b1;
      6'h04: ex_taken = (a == b);
      6'h05: ex_taken = (a != b);
      6'h02, 6'h03: begin
        ex_taken  = 1'b1;
        ex_target = {pc4[31:28], ir[25:0], 2'b00};
        if (op == 6'h03) begin
          ex_wen = 1'b1;
          ex_dst = 5'd31;
          ex_res = pc + 32'd8;
        end
      end
      default: ;
    endcase
  end

  logic [7:0]  ld_byte;
  logic [31:0] wb_data;

  always_comb begin
    ld_byte = ram_read_data[8*mem_addr_q[1:0] +: 8];
    case (op)
      6'h23:   wb_data = ram_read_data;
      6'h20:   wb_data = {{24{ld_byte[7]}}, ld_byte};
      6'h24:   wb_data = {24'h0, ld_byte};
      default: wb_data = res;
    endcase
  end

  always_comb begin
    state_nx = state;
    if (stall_all) begin
      // A stalled ID or load WB lost its one-cycle read data, so the access is replayed.
      if (state == S_ID) state_nx = S_IF;
      else if (state == S_WB && is_load) state_nx = S_MEM;
    end else begin
      case (state)
        S_IF:    if (rom_en_q) state_nx = S_ID;
        S_ID:    state_nx = S_EX;
        S_EX:    state_nx = (is_load || is_store) ? S_MEM : S_WB;
        S_MEM:   state_nx = is_store ? S_IF : S_WB;
        S_WB:    state_nx = S_IF;
        default: state_nx = S_IF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IF;
      pc         <= RESET_PC;
      npc        <= RESET_PC + 32'd4;
      ir         <= 32'h0;
      a          <= 32'h0;
      b          <= 32'h0;
      res        <= 32'h0;
      tgt        <= 32'h0;
      dst        <= 5'h0;
      wen        <= 1'b0;
      irq_q      <= 5'h0;
      rom_en_q   <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 4'h0;
      mem_addr_q <= 32'h0;
      wdata_q    <= 32'h0;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
    end else begin
      state <= state_nx;
      irq_q <= interrupt;
      if (stall_all) begin
        if (state == S_ID) rom_en_q <= 1'b1;
        if (state == S_WB && is_load) ram_en_q <= 1'b1;
      end else begin
        case (state)
          S_IF: rom_en_q <= ~rom_en_q;
          S_ID: begin
            ir <= rom_read_data;
            a  <= gpr[rom_read_data[25:21]];
            b  <= gpr[rom_read_data[20:16]];
          end
          S_EX: begin
            res <= ex_res;
            dst <= ex_dst;
            wen <= ex_wen;
            tgt <= ex_taken ? ex_target : npc + 32'd4;
            if (is_load || is_store) begin
              ram_en_q   <= 1'b1;
              mem_addr_q <= mem_addr;
              wdata_q    <= (op == 6'h28) ? {4{b[7:0]}} : b;
              ram_we_q   <= (op == 6'h2b) ? 4'hF :
                            (op == 6'h28) ? (4'b0001 << mem_addr[1:0]) : 4'h0;
            end
          end
          S_MEM: begin
            ram_en_q <= 1'b0;
            ram_we_q <= 4'h0;
            if (is_store) begin
              pc       <= npc;
              npc      <= tgt;
              rom_en_q <= 1'b1;
            end
          end
          S_WB: begin
            if (wen && dst != 5'd0) gpr[dst] <= wb_data;
            pc       <= npc;
            npc      <= tgt;
            rom_en_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef URANUS_DEBUG_EN
  logic dbg_vld, dbg_wr;
  assign dbg_vld              = rst && !stall_all && (state == S_WB);
  assign dbg_wr               = dbg_vld && wen && (dst != 5'd0);
  assign debug_pc_addr        = dbg_vld ? pc : 32'h0;
  assign debug_reg_write_en   = dbg_wr ? 4'hF : 4'h0;
  assign debug_reg_write_addr = dbg_wr ? dst : 5'h0;
  assign debug_reg_write_data = dbg_wr ? wb_data : 32'h0;
`else
  assign debug_pc_addr        = 32'h0;
  assign debug_reg_write_en   = 4'h0;
  assign debug_reg_write_addr = 5'h0;
  assign debug_reg_write_data = 32'h0;
`endif

endmodule

// File: tb/tb_uranus_cpu.sv
// Bench for uranus_cpu: program in a ROM model, RAM model, scoreboards for fetches, RAM accesses and retire trace.
module tb_uranus_cpu;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, stall_all;
  logic [4:0]  interrupt;
  logic        ram_en, rom_en;
  logic [3:0]  ram_write_en, debug_reg_write_en;
  logic [31:0] ram_addr, ram_write_data, ram_read_data, rom_addr, rom_read_data;
  logic [31:0] debug_pc_addr, debug_reg_write_data;
  logic [4:0]  debug_reg_write_addr;

  always #5 clk = ~clk;

  uranus_cpu #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall_all(stall_all), .interrupt(interrupt),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_read_data(rom_read_data),
    .debug_pc_addr(debug_pc_addr), .debug_reg_write_en(debug_reg_write_en),
    .debug_reg_write_addr(debug_reg_write_addr), .debug_reg_write_data(debug_reg_write_data)
  );

  logic [31:0] rom [0:63];
  logic [7:0]  ram [0:255];
  logic [31:0] rom_off;
  logic [7:0]  ram_wa;
  assign rom_off = rom_addr - RPC;
  assign ram_wa  = {ram_addr[7:2], 2'b00};

  always @(posedge clk) begin
    if (rom_en) rom_read_data <= rom[rom_off[7:2]];
    if (ram_en) begin
      ram_read_data <= {ram[ram_wa + 8'd3], ram[ram_wa + 8'd2], ram[ram_wa + 8'd1], ram[ram_wa]};
      for (int k = 0; k < 4; k++)
        if (ram_write_en[k]) ram[ram_wa + 8'(k)] <= ram_write_data[8*k +: 8];
    end
  end

  typedef struct packed { logic [3:0] we; logic [31:0] addr; logic [31:0] data; } bus_t;
  typedef struct packed { logic [31:0] pc; logic [4:0] rd; logic [31:0] val; } dbg_t;
  logic [31:0] fetch_q [$];
  bus_t        bus_q [$];
  dbg_t        dbg_q [$];
  bus_t        be;
  dbg_t        de;

  int n_tests = 0, n_fail = 0, np = 0, cyc = 0, n_fetch = 0;
  int fcyc [5];
  logic lb_seen = 1'b0, dbg_any = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  task automatic add(input logic [31:0] ins, input bit ex, input bit wr, input logic [4:0] rd, input logic [31:0] val);
    logic [31:0] pca;
    pca = RPC + 32'(np * 4);
    rom[np] = ins;
    if (ex) begin
      fetch_q.push_back(pca);
      if (wr && rd != 5'd0) dbg_q.push_back({pca, rd, val});
    end
    np++;
  endtask

  task automatic exp_bus(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
    bus_q.push_back({we, addr, data});
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst) begin
    if (rom_en) begin
      if (n_fetch < 5) fcyc[n_fetch] = cyc;
      n_fetch++;
      if (fetch_q.size() != 0) chk("fetch_addr", rom_addr, fetch_q.pop_front());
    end
    if (ram_en) begin
      if (ram_write_en == 4'h0 && ram_addr == 32'd9) lb_seen = 1'b1;
      if (bus_q.size() != 0) begin
        be = bus_q.pop_front();
        chk("ram_we", {28'h0, ram_write_en}, {28'h0, be.we});
        chk("ram_addr", ram_addr, be.addr);
        if (be.we != 4'h0) chk("ram_wdata", ram_write_data, be.data);
      end else chk("ram_extra_access", {31'h0, ram_en}, 32'h0);
    end
    if (stall_all)
      chk("stall_enables", {22'h0, rom_en, ram_en, ram_write_en, debug_reg_write_en}, 32'h0);
`ifdef URANUS_DEBUG_EN
    if (debug_reg_write_en != 4'h0) begin
      chk("dbg_en", {28'h0, debug_reg_write_en}, 32'hF);
      if (dbg_q.size() != 0) begin
        de = dbg_q.pop_front();
        chk("dbg_pc", debug_pc_addr, de.pc);
        chk("dbg_addr", {27'h0, debug_reg_write_addr}, {27'h0, de.rd});
        chk("dbg_data", debug_reg_write_data, de.val);
      end else chk("dbg_extra_write", {27'h0, debug_reg_write_addr}, 32'h0);
    end
`else
    if (debug_reg_write_en != 4'h0 || debug_pc_addr != 32'h0 ||
        debug_reg_write_addr != 5'h0 || debug_reg_write_data != 32'h0) dbg_any = 1'b1;
`endif
  end

  initial begin
    int t;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h0;

    add(i_ins(6'h0d, 0, 1, 16'h1234), 1, 1, 1, 32'h0000_1234);
    add(r_ins(1, 1, 2, 0, 6'h21),     1, 1, 2, 32'h0000_2468);
    add(i_ins(6'h2b, 0, 2, 16'd8),    1, 0, 0, 0); exp_bus(4'hF, 8, 32'h2468);
    add(i_ins(6'h23, 0, 3, 16'd8),    1, 1, 3, 32'h0000_2468); exp_bus(4'h0, 8, 0);
    add(i_ins(6'h2b, 0, 3, 16'd12),   1, 0, 0, 0); exp_bus(4'hF, 12, 32'h2468);
    add(i_ins(6'h0d, 0, 5, 16'h0080), 1, 1, 5, 32'h80);
    add(i_ins(6'h28, 0, 5, 16'd9),    1, 0, 0, 0); exp_bus(4'b0010, 9, 32'h8080_8080);
    add(i_ins(6'h20, 0, 6, 16'd9),    1, 1, 6, 32'hFFFF_FF80); exp_bus(4'h0, 9, 0);
    add(i_ins(6'h2b, 0, 6, 16'd16),   1, 0, 0, 0); exp_bus(4'hF, 16, 32'hFFFF_FF80);
    add(i_ins(6'h24, 0, 7, 16'd9),    1, 1, 7, 32'h80); exp_bus(4'h0, 9, 0);
    add(i_ins(6'h2b, 0, 7, 16'd20),   1, 0, 0, 0); exp_bus(4'hF, 20, 32'h80);
    add(i_ins(6'h09, 0, 0, 16'd5),    1, 1, 0, 32'd5);
    add(i_ins(6'h2b, 0, 0, 16'd24),   1, 0, 0, 0); exp_bus(4'hF, 24, 32'h0);
    add(i_ins(6'h04, 0, 0, 16'd2),    1, 0, 0, 0);
    add(i_ins(6'h0d, 0, 4, 16'd1),    1, 1, 4, 32'd1);
    add(i_ins(6'h0d, 0, 4, 16'd7),    0, 1, 4, 32'd7);
    add(i_ins(6'h2b, 0, 4, 16'd28),   1, 0, 0, 0); exp_bus(4'hF, 28, 32'd1);
    add(j_ins(6'h03, RPC + 32'h54),   1, 1, 31, RPC + 32'h4C);
    add(i_ins(6'h0d, 0, 8, 16'd2),    1, 1, 8, 32'd2);
    add(i_ins(6'h0d, 0, 8, 16'd9),    0, 1, 8, 32'd9);
    add(i_ins(6'h0d, 0, 8, 16'd9),    0, 1, 8, 32'd9);
    add(i_ins(6'h2b, 0, 31, 16'd32),  1, 0, 0, 0); exp_bus(4'hF, 32, RPC + 32'h4C);
    add(i_ins(6'h2b, 0, 8, 16'd36),   1, 0, 0, 0); exp_bus(4'hF, 36, 32'd2);
    add(i_ins(6'h0f, 0, 9, 16'hF00F), 1, 1, 9, 32'hF00F_0000);
    add(i_ins(6'h09, 9, 10, 16'hFFFF),1, 1, 10, 32'hF00E_FFFF);
    add(r_ins(10, 0, 11, 0, 6'h2a),   1, 1, 11, 32'd1);
    add(r_ins(10, 0, 12, 0, 6'h2b),   1, 1, 12, 32'd0);
    add(r_ins(0, 10, 13, 4, 6'h03),   1, 1, 13, 32'hFF00_EFFF);
    add(r_ins(0, 10, 14, 4, 6'h02),   1, 1, 14, 32'h0F00_EFFF);
    add(r_ins(10, 0, 15, 0, 6'h27),   1, 1, 15, 32'h0FF1_0000);
    add(r_ins(0, 1, 16, 0, 6'h23),    1, 1, 16, 32'hFFFF_EDCC);
    add(i_ins(6'h0e, 10, 17, 16'hFFFF), 1, 1, 17, 32'hF00E_0000);
    add(i_ins(6'h2b, 0, 11, 16'd40),  1, 0, 0, 0); exp_bus(4'hF, 40, 32'd1);
    add(i_ins(6'h2b, 0, 12, 16'd44),  1, 0, 0, 0); exp_bus(4'hF, 44, 32'd0);
    add(i_ins(6'h2b, 0, 13, 16'd48),  1, 0, 0, 0); exp_bus(4'hF, 48, 32'hFF00_EFFF);
    add(i_ins(6'h2b, 0, 14, 16'd52),  1, 0, 0, 0); exp_bus(4'hF, 52, 32'h0F00_EFFF);
    add(i_ins(6'h2b, 0, 15, 16'd56),  1, 0, 0, 0); exp_bus(4'hF, 56, 32'h0FF1_0000);
    add(i_ins(6'h2b, 0, 16, 16'd60),  1, 0, 0, 0); exp_bus(4'hF, 60, 32'hFFFF_EDCC);
    add(i_ins(6'h2b, 0, 17, 16'd64),  1, 0, 0, 0); exp_bus(4'hF, 64, 32'hF00E_0000);
    add(i_ins(6'h05, 1, 0, 16'd2),    1, 0, 0, 0);
    add(i_ins(6'h0a, 10, 18, 16'd0),  1, 1, 18, 32'd1);
    add(i_ins(6'h0d, 0, 18, 16'd5),   0, 1, 18, 32'd5);
    add(i_ins(6'h2b, 0, 18, 16'd68),  1, 0, 0, 0); exp_bus(4'hF, 68, 32'd1);
    add(i_ins(6'h0c, 10, 19, 16'h8001), 1, 1, 19, 32'h8001);
    add(i_ins(6'h2b, 0, 19, 16'd72),  1, 0, 0, 0); exp_bus(4'hF, 72, 32'h8001);
    add(i_ins(6'h04, 1, 0, 16'd2),    1, 0, 0, 0);
    add(i_ins(6'h0d, 0, 20, 16'd3),   1, 1, 20, 32'd3);
    add(i_ins(6'h2b, 0, 20, 16'd76),  1, 0, 0, 0); exp_bus(4'hF, 76, 32'd3);
    add(j_ins(6'h02, RPC + 32'hC0),   1, 0, 0, 0);
    add(32'h0,                        1, 0, 0, 0);

    rst = 1'b0; stall_all = 1'b0; interrupt = 5'h15;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_en", {31'h0, rom_en}, 32'h0);
    chk("rst_rom_addr", rom_addr, RPC);
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_ram_we", {28'h0, ram_write_en}, 32'h0);
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wdata", ram_write_data, 32'h0);
    chk("rst_dbg_en", {28'h0, debug_reg_write_en}, 32'h0);
    chk("rst_dbg_pc", debug_pc_addr, 32'h0);
    chk("rst_dbg_data", debug_reg_write_data, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first_rom_en", {31'h0, rom_en}, 32'h1);
    chk("first_rom_addr", rom_addr, RPC);

    // Freeze for 3 cycles starting in the WB cycle of the LB; the load must be replayed.
    t = 0;
    while (!lb_seen && t < 2000) begin @(posedge clk); t++; end
    chk("lb_reached", {31'h0, lb_seen}, 32'h1);
    #1;
    stall_all = 1'b1;
    bus_q.push_front({4'h0, 32'd9, 32'h0});
    repeat (3) @(posedge clk);
    #1;
    stall_all = 1'b0;

    t = 0;
    while ((bus_q.size() != 0 || fetch_q.size() != 0) && t < 3000) begin @(posedge clk); t++; end
    repeat (10) @(posedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    chk("fetch_q_drained", 32'(fetch_q.size()), 32'h0);
    chk("cpi_ori", 32'(fcyc[1] - fcyc[0]), 32'd4);
    chk("cpi_addu", 32'(fcyc[2] - fcyc[1]), 32'd4);
    chk("cpi_sw", 32'(fcyc[3] - fcyc[2]), 32'd4);
    chk("cpi_lw", 32'(fcyc[4] - fcyc[3]), 32'd5);
`ifdef URANUS_DEBUG_EN
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'h0);
`else
    chk("dbg_tied_zero", {31'h0, dbg_any}, 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
